// File: rtl/apb_rf_pkg.sv
// Shared definitions for the APB-to-register-file port-1 controller:
// FSM state encoding and bit positions of the individual error reasons.
package apb_rf_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ACC  = 3'd1,
        RD_WAIT = 3'd2,
        RD_ACC  = 3'd3,
        ERR_ACC = 3'd4
    } state_t;

    // Bit positions inside the decoder's error-reason vector
    localparam int ERR_ALIGN = 0;
    localparam int ERR_RANGE = 1;
    localparam int ERR_WPROT = 2;

endpackage

// File: rtl/apb_rf_ctrl_if.sv
// APB3 bus bundle between a bus master and the register-file controller.
interface apb_rf_ctrl_if #(
    parameter int data_width = 32,
    parameter int addr_width = 4
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [addr_width+1:0] paddr;
    logic [data_width-1:0] pwdata;
    logic                  pready;
    logic [data_width-1:0] prdata;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_rf_decode.sv
// Combinational address decode: register index plus misaligned, out-of-range
// and write-protect error detection for one APB setup phase.
module apb_rf_decode
    import apb_rf_pkg::*;
#(
    parameter int                   addr_width = 4,
    parameter int                   reg_depth  = 16,
    parameter logic [reg_depth-1:0] wp_mask    = '0
) (
    input  logic [addr_width+1:0] i_paddr,
    input  logic                  i_pwrite,
    output logic [addr_width-1:0] o_index,
    output logic                  o_err
);
    localparam int NREG = 2 ** addr_width;
    // Padded so that unimplemented indices can be looked up safely
    localparam logic [NREG-1:0] WP_FULL = NREG'(wp_mask);

    logic [2:0] w_why;

    always_comb begin
        o_index           = i_paddr[addr_width+1:2];
        w_why             = '0;
        w_why[ERR_ALIGN]  = (i_paddr[1:0] != 2'b00);
        w_why[ERR_RANGE]  = ({1'b0, o_index} >= (addr_width+1)'(reg_depth));
        w_why[ERR_WPROT]  = i_pwrite & WP_FULL[o_index];
        o_err             = |w_why;
    end
endmodule

// File: rtl/apb_rf_ctrl.sv
// APB3 slave sequencing port 1 of the two-port register file: zero-wait
// writes, one-wait reads (covers the registered read), PSLVERR on bad access.
module apb_rf_ctrl
    import apb_rf_pkg::*;
#(
    parameter int                   data_width = 32,
    parameter int                   addr_width = 4,
    parameter int                   reg_depth  = 16,
    parameter logic [reg_depth-1:0] wp_mask    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    apb_rf_ctrl_if.slave          apb,
    output logic [addr_width-1:0] rf_addr,
    output logic [data_width-1:0] rf_wdata,
    output logic                  rf_wr,
    input  logic [data_width-1:0] rf_rdata
);
    state_t                r_state;
    state_t                w_next;
    logic [addr_width-1:0] r_addr;
    logic [data_width-1:0] r_wdata;
    logic [addr_width-1:0] w_index;
    logic                  w_err;
    logic                  w_setup;

    apb_rf_decode #(
        .addr_width (addr_width),
        .reg_depth  (reg_depth),
        .wp_mask    (wp_mask)
    ) u_decode (
        .i_paddr  (apb.paddr),
        .i_pwrite (apb.pwrite),
        .o_index  (w_index),
        .o_err    (w_err)
    );

    assign w_setup  = apb.psel & ~apb.penable;
    assign rf_addr  = r_addr;
    assign rf_wdata = r_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_setup) begin
                r_addr  <= w_index;
                r_wdata <= apb.pwdata;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        apb.prdata  = '0;
        rf_wr       = 1'b0;
        case (r_state)
            IDLE: begin
                // An access phase without a preceding setup is ignored
                if (w_setup) begin
                    if (w_err)           w_next = ERR_ACC;
                    else if (apb.pwrite) w_next = WR_ACC;
                    else                 w_next = RD_WAIT;
                end
            end
            WR_ACC: begin
                apb.pready = 1'b1;
                // psel gating lets an aborted transfer skip the write
                rf_wr      = apb.psel & apb.penable;
                w_next     = IDLE;
            end
            RD_WAIT: begin
                w_next = apb.psel ? RD_ACC : IDLE;
            end
            RD_ACC: begin
                apb.pready = 1'b1;
                apb.prdata = rf_rdata;
                w_next     = IDLE;
            end
            ERR_ACC: begin
                apb.pready  = 1'b1;
                apb.pslverr = 1'b1;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_apb_rf_ctrl.sv
// Directed bench for apb_rf_ctrl with a behavioural register-file port model
// (reg_depth=12, register 0 write-protected).
module tb_apb_rf_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;
    logic        rf_wr;
    logic [31:0] mem [16];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    apb_rf_ctrl_if #(.data_width(32), .addr_width(4)) bus ();

    apb_rf_ctrl #(
        .data_width (32),
        .addr_width (4),
        .reg_depth  (12),
        .wp_mask    (12'h001)
    ) dut (
        .clk      (clk),
        .reset    (rst),
        .apb      (bus.slave),
        .rf_addr  (rf_addr),
        .rf_wdata (rf_wdata),
        .rf_wr    (rf_wr),
        .rf_rdata (rf_rdata)
    );

    // Register-file port 1: synchronous write, registered read
    always @(posedge clk) begin
        if (rf_wr) mem[rf_addr] <= rf_wdata;
        rf_rdata <= mem[rf_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full APB transfer starting just after a rising edge; returns just after the closing edge
    task automatic xfer(input logic wr, input logic [5:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int waits, output int wrs);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wd;
        waits = 0; wrs = 0;
        @(negedge clk);
        if (rf_wr) wrs++;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        while (1) begin
            @(negedge clk);
            if (rf_wr) wrs++;
            if (bus.pready) break;
            waits++;
            if (waits > 8) break;
        end
        rd  = bus.prdata;
        err = bus.pslverr;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          wt, wrs;

        rst = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;

        @(negedge clk);
        chk("rst_pready",  {31'b0, bus.pready},  32'd0);
        chk("rst_pslverr", {31'b0, bus.pslverr}, 32'd0);
        chk("rst_prdata",  bus.prdata,           32'd0);
        chk("rst_rf_wr",   {31'b0, rf_wr},       32'd0);
        chk("rst_rf_addr", {28'b0, rf_addr},     32'd0);
        chk("rst_rf_wdata", rf_wdata,            32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Asynchronous reset in the middle of a write access
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 6'h10; bus.pwdata = 32'h55;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(negedge clk);
        chk("midwr_rf_wr_before", {31'b0, rf_wr}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midwr_rf_wr_after", {31'b0, rf_wr},       32'd0);
        chk("midwr_pready",      {31'b0, bus.pready},  32'd0);
        chk("midwr_rf_addr",     {28'b0, rf_addr},     32'd0);
        chk("midwr_rf_wdata",    rf_wdata,             32'd0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midwr_mem4", mem[4], 32'hA000_0004);
        @(negedge clk);
        chk("midwr_idle_pready", {31'b0, bus.pready}, 32'd0);
        @(posedge clk); #1;

        // Normal write then read of register 2
        xfer(1'b1, 6'h08, 32'hDEAD_BEEF, rd, er, wt, wrs);
        chk("wr_err",     {31'b0, er},      32'd0);
        chk("wr_waits",   wt,               32'd0);
        chk("wr_pulses",  wrs,              32'd1);
        chk("wr_rf_addr", {28'b0, rf_addr}, 32'd2);
        chk("wr_mem2",    mem[2],           32'hDEAD_BEEF);
        idle();
        xfer(1'b0, 6'h08, 32'h0, rd, er, wt, wrs);
        chk("rd_data",  rd,            32'hDEAD_BEEF);
        chk("rd_err",   {31'b0, er},   32'd0);
        chk("rd_waits", wt,            32'd1);
        chk("rd_pulses", wrs,          32'd0);
        idle();

        // Misaligned write
        xfer(1'b1, 6'h06, 32'hCAFE_F00D, rd, er, wt, wrs);
        chk("mis_err",    {31'b0, er}, 32'd1);
        chk("mis_waits",  wt,          32'd0);
        chk("mis_pulses", wrs,         32'd0);
        chk("mis_prdata", rd,          32'd0);
        chk("mis_mem1",   mem[1],      32'hA000_0001);
        idle();

        // Write-protected register 0
        xfer(1'b1, 6'h00, 32'h1234_5678, rd, er, wt, wrs);
        chk("wp_err",    {31'b0, er}, 32'd1);
        chk("wp_pulses", wrs,         32'd0);
        chk("wp_mem0",   mem[0],      32'hA000_0000);
        idle();
        xfer(1'b0, 6'h00, 32'h0, rd, er, wt, wrs);
        chk("wp_rd_data", rd,          32'hA000_0000);
        chk("wp_rd_err",  {31'b0, er}, 32'd0);
        idle();

        // Out-of-range read (index 12)
        xfer(1'b0, 6'h30, 32'h0, rd, er, wt, wrs);
        chk("rng_err",    {31'b0, er}, 32'd1);
        chk("rng_prdata", rd,          32'd0);
        chk("rng_waits",  wt,          32'd0);
        idle();

        // Back-to-back writes with no idle cycle between them
        xfer(1'b1, 6'h04, 32'h1111_1111, rd, er, wt, wrs);
        chk("b2b1_pulses", wrs,         32'd1);
        chk("b2b1_err",    {31'b0, er}, 32'd0);
        xfer(1'b1, 6'h0C, 32'h2222_2222, rd, er, wt, wrs);
        chk("b2b2_pulses", wrs,         32'd1);
        chk("b2b2_waits",  wt,          32'd0);
        chk("b2b_mem1",    mem[1],      32'h1111_1111);
        chk("b2b_mem3",    mem[3],      32'h2222_2222);

        // Read of 0x04 aborted during its wait state
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 6'h04;
        @(posedge clk); #1;
        bus.psel = 1'b0;
        @(negedge clk);
        chk("abort_wait_pready", {31'b0, bus.pready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_after_pready", {31'b0, bus.pready}, 32'd0);
        chk("abort_after_prdata", bus.prdata,          32'd0);
        @(posedge clk); #1;
        xfer(1'b0, 6'h0C, 32'h0, rd, er, wt, wrs);
        chk("post_abort_data",  rd,          32'h2222_2222);
        chk("post_abort_err",   {31'b0, er}, 32'd0);
        chk("post_abort_waits", wt,          32'd1);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
